// File: rtl/req_encoder.sv
// req_encoder
//   Pending-request encoder. Up to 2**SIZE request lines (interrupt or event
//   sources) are captured into a sticky pending register. One pending request
//   is offered at a time as a SIZE-bit index on a valid/ready handshake.
//   This is the inverse of the index-to-one-hot write decoder.
//
//   Optional feature macro: REQ_ENCODER_ROUND_ROBIN_EN
//     undefined : fixed priority, lowest eligible index wins
//     defined   : round-robin, starting at a pointer that moves to k+1 after
//                 index k is granted
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_in     in   [N-1:0] request pulses, bit i sets pending[i]
//   mask       in   [N-1:0] eligibility, only pending & mask may be selected
//   out_ready  in   consumer accepts the offered index
//   out_valid  out  out_idx is valid
//   out_idx    out  [SIZE-1:0] index of the offered request
//   pending    out  [N-1:0] pending register
//   pend_cnt   out  [SIZE:0] population count of pending
module req_encoder #(
  parameter int SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2**SIZE-1:0]   req_in,
  input  logic [2**SIZE-1:0]   mask,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [SIZE-1:0]      out_idx,
  output logic [2**SIZE-1:0]   pending,
  output logic [SIZE:0]        pend_cnt
);

  localparam int N = 2**SIZE;

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [SIZE-1:0] idx_next;
  logic            hs;
  logic [N-1:0]    grant_vec;
  logic [N-1:0]    pending_next;
  logic [N-1:0]    eligible;
  logic            any_eligible;
  logic [SIZE-1:0] sel_idx;

  assign out_valid = (state == OFFER);
  assign hs        = out_valid & out_ready;

  always_comb begin
    grant_vec = '0;
    if (hs) grant_vec[out_idx] = 1'b1;
  end

  // A new request on the granted line in the handshake cycle survives the clear.
  assign pending_next = req_in | (pending & ~grant_vec);

  // The granted bit is removed so a back-to-back offer never repeats it.
  assign eligible     = pending & mask & ~grant_vec;
  assign any_eligible = |eligible;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [SIZE-1:0] ptr;
  logic [SIZE-1:0] base;

  // During a handshake the search already starts past the granted index, so the
  // back-to-back selection matches what the updated pointer would choose.
  assign base = hs ? out_idx + SIZE'(1) : ptr;

  always_comb begin
    logic            found;
    logic [SIZE-1:0] cand;
    sel_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = base + SIZE'(k);
      if (!found && eligible[cand]) begin
        sel_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= out_idx + SIZE'(1);
    end
  end
`else
  // Scanning downward lets the lowest eligible index overwrite any higher one.
  always_comb begin
    sel_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[k]) sel_idx = SIZE'(k);
    end
  end
`endif

  always_comb begin
    state_next = state;
    idx_next   = out_idx;
    case (state)
      IDLE: begin
        if (any_eligible) begin
          state_next = OFFER;
          idx_next   = sel_idx;
        end
      end
      OFFER: begin
        if (hs) begin
          if (any_eligible) begin
            idx_next = sel_idx;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_idx <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      out_idx <= idx_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int k = 0; k < N; k++) begin
      pend_cnt = pend_cnt + (SIZE+1)'(pending[k]);
    end
  end

endmodule

// File: tb/tb_req_encoder.sv
// tb_req_encoder
//   Directed and random stimulus for req_encoder, checked against a
//   behavioural model of the pending set and the offer/grant rules.
//   Honors REQ_ENCODER_ROUND_ROBIN_EN the same way the design does.
module tb_req_encoder;

  localparam int SIZE = 5;
  localparam int N    = 32;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_in;
  logic [N-1:0]    mask;
  logic            out_ready;
  logic            out_valid;
  logic [SIZE-1:0] out_idx;
  logic [N-1:0]    pending;
  logic [SIZE:0]   pend_cnt;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] m_pending;
  bit           m_valid;
  int           m_idx;
  int           m_ptr;

  req_encoder #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelReset();
    m_pending = '0;
    m_valid   = 1'b0;
    m_idx     = 0;
    m_ptr     = 0;
  endfunction

  // First eligible index found walking upward from base, wrapping around.
  function automatic int pickFrom(logic [N-1:0] elig, int base);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (base + k) % N;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  // One clock edge of the intended behaviour, using the inputs of the ending cycle.
  function automatic void modelStep();
    bit           hs;
    logic [N-1:0] nxt;
    logic [N-1:0] elig;
    int           j;
    hs = m_valid && out_ready;
    for (int i = 0; i < N; i++) begin
      nxt[i] = req_in[i] | (m_pending[i] & ~(hs && i == m_idx));
    end
    if (!m_valid) begin
      j = pickFrom(m_pending & mask, RR ? m_ptr : 0);
      if (j >= 0) begin
        m_valid = 1'b1;
        m_idx   = j;
      end
    end else if (hs) begin
      if (RR) m_ptr = (m_idx + 1) % N;
      elig        = m_pending & mask;
      elig[m_idx] = 1'b0;
      j = pickFrom(elig, RR ? m_ptr : 0);
      if (j >= 0) m_idx = j;
      else        m_valid = 1'b0;
    end
    m_pending = nxt;
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_valid"}, out_valid, m_valid);
    if (m_valid) checkValue({tag, "_idx"}, out_idx, m_idx);
    checkValue({tag, "_pending"}, pending, m_pending);
    checkValue({tag, "_cnt"}, pend_cnt, $countones(m_pending));
  endtask

  // Drive one cycle of inputs, clock it, advance the model, check #1 later.
  task automatic applyStimulus(input string tag, input logic [N-1:0] r,
                               input logic [N-1:0] m, input logic rdy);
    req_in    = r;
    mask      = m;
    out_ready = rdy;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  // Asynchronous reset: out_valid must fall with no clock edge.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkValue({tag, "_async_valid"}, out_valid, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] m;
    logic         rdy;
    int           first2;
    int           second2;

    $display("[TB] req_encoder bench, round robin = %0d", RR);
    rst_n     = 1'b0;
    req_in    = '1;
    mask      = '1;
    out_ready = 1'b0;
    modelReset();

    // Reset holds everything clear even with every request high.
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_valid", out_valid, 0);
    checkValue("reset_idx", out_idx, 0);
    checkValue("reset_pending", pending, 0);
    checkValue("reset_cnt", pend_cnt, 0);
    rst_n = 1'b1;
    applyStimulus("release", '1, '0, 1'b0);
    checkValue("release_pending", pending, {N{1'b1}});
    checkValue("release_cnt", pend_cnt, 32);
    for (int c = 0; c < 34; c++) applyStimulus("drain_all", '0, '1, 1'b1);
    checkValue("drain_all_empty", pending, 0);

    // Single request latency.
    applyStimulus("single_c0", 32'h0000_0080, '1, 1'b1);
    checkValue("single_pend7", pending[7], 1);
    applyStimulus("single_c1", '0, '1, 1'b1);
    checkValue("single_valid", out_valid, 1);
    checkValue("single_idx", out_idx, 7);
    applyStimulus("single_c2", '0, '1, 1'b1);
    checkValue("single_cleared", pending[7], 0);
    checkValue("single_idle", out_valid, 0);

    // Ordering, starting from a fresh pointer.
    doReset("ord");
    applyStimulus("ord_pulse", 32'h0010_0208, '1, 1'b1);
    applyStimulus("ord_g0", '0, '1, 1'b1);
    checkValue("ord_first", out_idx, 3);
    applyStimulus("ord_g1", '0, '1, 1'b1);
    checkValue("ord_second", out_idx, 9);
    applyStimulus("ord_g2", '0, '1, 1'b1);
    checkValue("ord_third", out_idx, 20);
    applyStimulus("ord_idle", 32'h0200_0008, '1, 1'b1);
    applyStimulus("ord2_pend", '0, '1, 1'b1);
    first2  = RR ? 25 : 3;
    second2 = RR ? 3 : 25;
    checkValue("ord2_first", out_idx, first2);
    applyStimulus("ord2_next", '0, '1, 1'b1);
    checkValue("ord2_second", out_idx, second2);
    applyStimulus("ord2_done", '0, '1, 1'b1);

    // Backpressure: the offer stays put while mask and pending change.
    applyStimulus("bp_pulse", 32'h0000_0010, '1, 1'b0);
    applyStimulus("bp_offer", '0, '1, 1'b0);
    checkValue("bp_offer_idx", out_idx, 4);
    for (int c = 0; c < 5; c++) begin
      applyStimulus("bp_hold", (c == 2) ? 32'h0000_0002 : 32'h0, '0, 1'b0);
      checkValue("bp_hold_valid", out_valid, 1);
      checkValue("bp_hold_idx", out_idx, 4);
    end
    applyStimulus("bp_hs", '0, '0, 1'b1);
    checkValue("bp_after_valid", out_valid, 0);
    checkValue("bp_after_cnt", pend_cnt, 1);
    applyStimulus("bp_masked", '0, '0, 1'b1);
    checkValue("bp_masked_valid", out_valid, 0);
    applyStimulus("bp_unmask", '0, '1, 1'b1);
    checkValue("bp_unmask_idx", out_idx, 1);
    applyStimulus("bp_done", '0, '1, 1'b1);

    // Set wins over clear on the granted line.
    applyStimulus("sw_pulse", 32'h0000_0010, '1, 1'b0);
    applyStimulus("sw_offer", '0, '1, 1'b0);
    applyStimulus("sw_hs", 32'h0000_0010, '1, 1'b1);
    checkValue("sw_kept", pending[4], 1);
    applyStimulus("sw_reoffer", '0, '1, 1'b0);
    checkValue("sw_reoffer_valid", out_valid, 1);
    checkValue("sw_reoffer_idx", out_idx, 4);
    applyStimulus("sw_done", '0, '1, 1'b1);

    // Wrap past the top index, then drop the offer with reset.
    doReset("wrap_pre");
    applyStimulus("wrap_pulse", 32'h8000_0000, '1, 1'b0);
    applyStimulus("wrap_offer", '0, '1, 1'b1);
    checkValue("wrap_idx31", out_idx, 31);
    applyStimulus("wrap_hs", 32'h4000_0001, '1, 1'b1);
    applyStimulus("wrap_next", '0, '1, 1'b0);
    checkValue("wrap_first0", out_idx, 0);
    doReset("wrap_mid_offer");
    applyStimulus("post_reset", '0, '1, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      r   = $urandom & $urandom & $urandom;
      m   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) r = '0;
      applyStimulus("rand", r, m, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_encoder.md
# req_encoder

Pending-request encoder for the multicycle processor. It collects up to 2**SIZE request lines, such as interrupt or event sources, into a sticky pending register. It then presents one pending request at a time as a SIZE-bit index on a valid/ready handshake. It is the inverse of the index-to-one-hot write decoder: one-hot events in, a binary index out.

## Interface
Parameters:
- SIZE, 5, index width; N = 2**SIZE request lines

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_in  input  N  request pulses; bit i high for any cycle sets pending[i]
- mask  input  N  eligibility; only pending & mask bits may be selected
- out_ready  input  1  consumer accepts the offered index
- out_valid  output  1  out_idx is valid
- out_idx  output  SIZE  index of the offered request
- pending  output  N  pending register
- pend_cnt  output  SIZE+1  population count of pending (0..N)

## Operation
- pending:
  - Per bit, next = req_in[i] | (pending[i] & ~(hs & out_idx == i)), where hs = out_valid & out_ready.
  - Set wins over clear in the same cycle.
- States:
  - IDLE (out_valid = 0).
  - OFFER (out_valid = 1).
- IDLE transitions:
  - eligible = pending & mask; if nonzero, register the selected index into out_idx and go to OFFER; otherwise stay.
  - Selection uses only registered pending, never same-cycle req_in.
- OFFER transitions:
  - out_idx is held stable until hs; out_valid never drops without hs.
  - Changes to mask or pending do not retract or alter the offer.
- On hs, eligible' = pending & mask with the granted bit removed:
  - eligible' nonzero: load the next selection into out_idx and stay in OFFER (back-to-back, one grant per cycle).
  - Otherwise: go to IDLE.
- Selection without the macro: fixed priority, lowest index first.
- pend_cnt: combinational popcount of the pending register, SIZE+1 bits wide, so N = 32 reads as 6'd32.

## Timing
- Reset (asynchronous, immediate):
  - pending = 0, out_valid = 0, out_idx = 0, pend_cnt = 0.
  - Round-robin pointer = 0 when the macro is defined.
  - State = IDLE.
  - Reset asserted mid-offer drops the offer without a handshake.
- Latency:
  - req_in[i] high in cycle 0 gives pending[i] = 1 in cycle 1.
  - With nothing else eligible, out_valid = 1 and out_idx = i in cycle 2.
- Throughput: one handshake per cycle while eligible requests remain.
- Granted bit:
  - pending[i] reads 0 in the cycle after hs, unless req_in[i] was high in the hs cycle.
  - That request may be selected again later.
- A request whose mask bit is 0 stays pending indefinitely and is counted in pend_cnt.

## Configuration
- Macro: REQ_ENCODER_ROUND_ROBIN_EN.
- Defined:
  - SIZE-bit pointer ptr, reset to 0.
  - Selection is the first eligible index at or above ptr, wrapping from N-1 to 0.
  - On hs of index k: ptr = (k+1) mod N, so a grant of 31 sets ptr to 0.
  - ptr updates only on hs.
- Undefined:
  - No pointer register.
  - Fixed lowest-index priority as described in Operation.

## Test plan
- Reset: hold rst_n = 0 with req_in = all ones -> out_valid = 0, out_idx = 0, pending = 0, pend_cnt = 0; release -> pending = all ones one cycle later, pend_cnt = 32.
- Single request: mask = all ones, out_ready = 1, req_in[7] pulsed in cycle 0 -> out_valid = 1 and out_idx = 7 in cycle 2; pending[7] = 0 and out_valid = 0 in cycle 3.
- Ordering: req_in bits 3, 9, 20 pulsed together, out_ready = 1 -> out_idx 3, 9, 20 on consecutive cycles. Then bits 3 and 25 pulsed:
  - macro defined (ptr = 21): 25 then 3.
  - macro undefined: 3 then 25.
- Backpressure: index 4 offered, out_ready = 0 for 5 cycles, mask set to 0 and req_in[1] pulsed meanwhile -> out_valid = 1 and out_idx = 4 held throughout; on out_ready = 1, handshake completes, then IDLE while mask = 0 and pend_cnt = 1.
- Set-wins collision: req_in[4] high in the hs cycle of index 4 -> pending[4] stays 1, and index 4 is offered again once nothing else is eligible.
- Wrap and async reset (macro defined):
  - grant index 31, then pulse bits 0 and 30 -> 0 is offered first.
  - assert rst_n low mid-offer -> out_valid = 0 immediately, with no clock edge required.
